// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and state encoding for the iterative Vedic MAC
package mac_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      FIX  = 2'd2,
      OUT  = 2'd3
   } state_t;

endpackage

// File: rtl/vedic_4bit_multiplier.sv
// rtl/vedic_4bit_multiplier.sv - combinational 4x4 Vedic (Urdhva Tiryagbhyam) digit multiplier
module vedic_4bit_multiplier (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [7:0] p_o
);

   function automatic logic [3:0] vedic2(input logic [1:0] a, input logic [1:0] b);
      logic t1, t2, c, hh;
      logic [3:0] p;
      t1   = a[1] & b[0];
      t2   = a[0] & b[1];
      c    = t1 & t2;
      hh   = a[1] & b[1];
      p[0] = a[0] & b[0];
      p[1] = t1 ^ t2;
      p[2] = hh ^ c;
      p[3] = hh & c;
      return p;
   endfunction

   logic [3:0] q0, q1, q2, q3;
   logic [4:0] mid;

   assign q0  = vedic2(a_i[1:0], b_i[1:0]);
   assign q1  = vedic2(a_i[3:2], b_i[1:0]);
   assign q2  = vedic2(a_i[1:0], b_i[3:2]);
   assign q3  = vedic2(a_i[3:2], b_i[3:2]);
   // Cross products share weight 2^2, so add them before shifting into place.
   assign mid = {1'b0, q1} + {1'b0, q2};
   assign p_o = {4'b0000, q0} + {1'b0, mid, 2'b00} + {q3, 4'b0000};

endmodule

// File: rtl/vedic_iter_mac.sv
// rtl/vedic_iter_mac.sv - iterative signed/unsigned multiply-accumulate built on one shared 4x4 Vedic core
module vedic_iter_mac
   import mac_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_signed,
   input  logic                 in_acc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_prod,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic                 out_ovf
);

   localparam int D  = WIDTH / DIGIT_W;
   localparam int PW = 2 * WIDTH;
   localparam int CW = (D > 1) ? $clog2(D) : 1;
   localparam logic [CW-1:0] LAST = CW'(D - 1);

   state_t                 state_q;
   logic [WIDTH-1:0]       a_mag_q, b_mag_q;
   logic                   neg_q, sgn_q, accm_q;
   logic [CW-1:0]          i_q, j_q;
   logic [PW-1:0]          partial_q;
   logic [PW-1:0]          prod_q;
   logic [ACC_WIDTH-1:0]   acc_q;
   logic                   ovf_q;
   logic                   out_valid_q;

   logic [WIDTH-1:0]       a_abs, b_abs, a_sh, b_sh;
   logic [7:0]             core_p;
   logic [PW-1:0]          core_ext, partial_d, prod_d;
   logic [CW+2:0]          shamt;
   logic [ACC_WIDTH-1:0]   prod_ext, acc_base, acc_d;
   logic [ACC_WIDTH:0]     sum;
   logic                   ovf_add, ovf_d;

   // 0x80..0 negates to itself, which is the correct unsigned magnitude.
   assign a_abs = (in_signed & in_a[WIDTH-1]) ? -in_a : in_a;
   assign b_abs = (in_signed & in_b[WIDTH-1]) ? -in_b : in_b;

   assign a_sh  = a_mag_q >> {i_q, 2'b00};
   assign b_sh  = b_mag_q >> {j_q, 2'b00};

   vedic_4bit_multiplier u_core (
      .a_i (a_sh[DIGIT_W-1:0]),
      .b_i (b_sh[DIGIT_W-1:0]),
      .p_o (core_p)
   );

   assign shamt = {({1'b0, i_q} + {1'b0, j_q}), 2'b00};

   always_comb begin
      core_ext      = '0;
      core_ext[7:0] = core_p;
   end

   assign partial_d = partial_q + (core_ext << shamt);
   assign prod_d    = neg_q ? -partial_q : partial_q;

   always_comb begin
      prod_ext         = {ACC_WIDTH{sgn_q & prod_d[PW-1]}};
      prod_ext[PW-1:0] = prod_d;
   end

   assign acc_base = accm_q ? acc_q : '0;
   assign sum      = {1'b0, acc_base} + {1'b0, prod_ext};
   assign acc_d    = sum[ACC_WIDTH-1:0];
   assign ovf_add  = sgn_q ? ((acc_base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                              (sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]))
                           : sum[ACC_WIDTH];
   // An overwrite cannot overflow, so only accumulate mode keeps the old flag.
   assign ovf_d    = ovf_add | (accm_q & ovf_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_mag_q     <= '0;
         b_mag_q     <= '0;
         neg_q       <= 1'b0;
         sgn_q       <= 1'b0;
         accm_q      <= 1'b0;
         i_q         <= '0;
         j_q         <= '0;
         partial_q   <= '0;
         prod_q      <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_mag_q   <= a_abs;
                  b_mag_q   <= b_abs;
                  neg_q     <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                  sgn_q     <= in_signed;
                  accm_q    <= in_acc;
                  partial_q <= '0;
                  i_q       <= '0;
                  j_q       <= '0;
                  state_q   <= MUL;
               end
            end
            MUL: begin
               partial_q <= partial_d;
               if (j_q == LAST) begin
                  j_q <= '0;
                  if (i_q == LAST) begin
                     state_q <= FIX;
                  end else begin
                     i_q <= i_q + CW'(1);
                  end
               end else begin
                  j_q <= j_q + CW'(1);
               end
            end
            FIX: begin
               prod_q      <= prod_d;
               acc_q       <= acc_d;
               ovf_q       <= ovf_d;
               out_valid_q <= 1'b1;
               state_q     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign out_prod  = prod_q;
   assign out_acc   = acc_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_vedic_iter_mac.sv
// tb/tb_vedic_iter_mac.sv - directed self-checking bench for vedic_iter_mac
module tb_vedic_iter_mac;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   fails = 0;

   // inst 0: WIDTH=8 ACC=24, inst 1: WIDTH=8 ACC=16, inst 2: WIDTH=16 ACC=32
   logic        v0 = 0, r0 = 0, s0 = 0, c0 = 0, rdy0, ov0, f0;
   logic [7:0]  a0 = 0, b0 = 0;
   logic [15:0] p0;
   logic [23:0] acc0;
   logic        v1 = 0, r1 = 0, s1 = 0, c1 = 0, rdy1, ov1, f1;
   logic [7:0]  a1 = 0, b1 = 0;
   logic [15:0] p1;
   logic [15:0] acc1;
   logic        v2 = 0, r2 = 0, s2 = 0, c2 = 0, rdy2, ov2, f2;
   logic [15:0] a2 = 0, b2 = 0;
   logic [31:0] p2;
   logic [31:0] acc2;

   always #5 clk = ~clk;

   vedic_iter_mac #(.WIDTH(8), .ACC_WIDTH(24)) u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_a(a0), .in_b(b0),
      .in_signed(s0), .in_acc(c0), .out_valid(ov0), .out_ready(r0), .out_prod(p0),
      .out_acc(acc0), .out_ovf(f0));

   vedic_iter_mac #(.WIDTH(8), .ACC_WIDTH(16)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_a(a1), .in_b(b1),
      .in_signed(s1), .in_acc(c1), .out_valid(ov1), .out_ready(r1), .out_prod(p1),
      .out_acc(acc1), .out_ovf(f1));

   vedic_iter_mac #(.WIDTH(16), .ACC_WIDTH(32)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_a(a2), .in_b(b2),
      .in_signed(s2), .in_acc(c2), .out_valid(ov2), .out_ready(r2), .out_prod(p2),
      .out_acc(acc2), .out_ovf(f2));

   function automatic logic get_ov(input int inst);
      case (inst)
         0: return ov0;
         1: return ov1;
         default: return ov2;
      endcase
   endfunction

   function automatic logic get_rdy(input int inst);
      case (inst)
         0: return rdy0;
         1: return rdy1;
         default: return rdy2;
      endcase
   endfunction

   task automatic start(input int inst, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic acc);
      @(negedge clk);
      case (inst)
         0: begin a0 = a[7:0]; b0 = b[7:0]; s0 = s; c0 = acc; v0 = 1'b1; end
         1: begin a1 = a[7:0]; b1 = b[7:0]; s1 = s; c1 = acc; v1 = 1'b1; end
         default: begin a2 = a; b2 = b; s2 = s; c2 = acc; v2 = 1'b1; end
      endcase
      checks++;
      if (get_rdy(inst) !== 1'b1) begin
         fails++;
         $display("FAIL in_ready_at_accept inst %0d got %b exp 1", inst, get_rdy(inst));
      end
      @(posedge clk);
      #1;
      v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
   endtask

   task automatic wait_out(input int inst, output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!get_ov(inst) && lat < 100);
      checks++;
      if (get_ov(inst) !== 1'b1) begin
         fails++;
         $display("FAIL out_valid_timeout inst %0d got %b exp 1", inst, get_ov(inst));
      end
   endtask

   task automatic pop(input int inst);
      @(negedge clk);
      case (inst)
         0: r0 = 1'b1;
         1: r1 = 1'b1;
         default: r2 = 1'b1;
      endcase
      @(posedge clk);
      #1;
      r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", rdy0); end
      checks++; if (ov0 !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", ov0); end
      checks++; if (p0 !== 16'h0) begin fails++; $display("FAIL reset_prod got %h exp 0000", p0); end
      checks++; if (acc0 !== 24'h0) begin fails++; $display("FAIL reset_acc got %h exp 000000", acc0); end
      checks++; if (f0 !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", f0); end
      checks++; if (ov2 !== 1'b0 || rdy2 !== 1'b1) begin fails++; $display("FAIL reset_wide got valid=%b ready=%b exp 0/1", ov2, rdy2); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unsigned_max();
      int lat;
      start(0, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
      wait_out(0, lat);
      checks++; if (lat !== 5) begin fails++; $display("FAIL latency8 got %0d exp 5", lat); end
      checks++; if (p0 !== 16'hFE01) begin fails++; $display("FAIL umax_prod got %h exp fe01", p0); end
      checks++; if (acc0 !== 24'h00FE01) begin fails++; $display("FAIL umax_acc got %h exp 00fe01", acc0); end
      checks++; if (f0 !== 1'b0) begin fails++; $display("FAIL umax_ovf got %b exp 0", f0); end
      pop(0);
      checks++; if (ov0 !== 1'b0 || rdy0 !== 1'b1) begin fails++; $display("FAIL umax_after_pop got valid=%b ready=%b exp 0/1", ov0, rdy0); end
   endtask

   task automatic test_back_to_back_signed();
      int lat;
      start(0, 16'h0080, 16'h0080, 1'b1, 1'b0);
      wait_out(0, lat);
      checks++; if (p0 !== 16'h4000) begin fails++; $display("FAIL s80x80_prod got %h exp 4000", p0); end
      checks++; if (acc0 !== 24'h004000) begin fails++; $display("FAIL s80x80_acc got %h exp 004000", acc0); end
      pop(0);
      start(0, 16'h0080, 16'h007F, 1'b1, 1'b1);
      wait_out(0, lat);
      checks++; if (lat !== 5) begin fails++; $display("FAIL b2b_latency got %0d exp 5", lat); end
      checks++; if (p0 !== 16'hC080) begin fails++; $display("FAIL s80x7f_prod got %h exp c080", p0); end
      checks++; if (acc0 !== 24'h000080) begin fails++; $display("FAIL s80x7f_acc got %h exp 000080", acc0); end
      checks++; if (f0 !== 1'b0) begin fails++; $display("FAIL s80x7f_ovf got %b exp 0", f0); end
      pop(0);
   endtask

   task automatic test_acc16_overflow();
      int lat;
      start(1, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
      wait_out(1, lat);
      checks++; if (acc1 !== 16'hFE01) begin fails++; $display("FAIL acc16_first got %h exp fe01", acc1); end
      pop(1);
      start(1, 16'h0010, 16'h0020, 1'b0, 1'b1);
      wait_out(1, lat);
      checks++; if (acc1 !== 16'h0001) begin fails++; $display("FAIL acc16_wrap got %h exp 0001", acc1); end
      checks++; if (f1 !== 1'b1) begin fails++; $display("FAIL acc16_ovf_set got %b exp 1", f1); end
      pop(1);
      start(1, 16'h0002, 16'h0003, 1'b0, 1'b0);
      wait_out(1, lat);
      checks++; if (acc1 !== 16'h0006) begin fails++; $display("FAIL acc16_overwrite got %h exp 0006", acc1); end
      checks++; if (f1 !== 1'b0) begin fails++; $display("FAIL acc16_ovf_clear got %b exp 0", f1); end
      pop(1);
   endtask

   task automatic test_backpressure();
      int lat;
      start(0, 16'h0012, 16'h0034, 1'b0, 1'b0);
      wait_out(0, lat);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (n == 3) begin a0 = 8'h05; b0 = 8'h05; c0 = 1'b1; v0 = 1'b1; end
         else v0 = 1'b0;
         checks++;
         if (ov0 !== 1'b1 || rdy0 !== 1'b0 || p0 !== 16'h03A8 || acc0 !== 24'h0003A8) begin
            fails++;
            $display("FAIL backpressure_hold cyc %0d got valid=%b ready=%b prod=%h acc=%h exp 1/0/03a8/0003a8",
                     n, ov0, rdy0, p0, acc0);
         end
      end
      v0 = 1'b0;
      pop(0);
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         checks++;
         if (ov0 !== 1'b0 || rdy0 !== 1'b1 || p0 !== 16'h03A8) begin
            fails++;
            $display("FAIL dropped_pulse cyc %0d got valid=%b ready=%b prod=%h exp 0/1/03a8", n, ov0, rdy0, p0);
         end
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      start(0, 16'h0011, 16'h0011, 1'b0, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (ov0 !== 1'b0) begin fails++; $display("FAIL midreset_valid got %b exp 0", ov0); end
      checks++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL midreset_ready got %b exp 1", rdy0); end
      checks++; if (acc0 !== 24'h0) begin fails++; $display("FAIL midreset_acc got %h exp 000000", acc0); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         checks++;
         if (ov0 !== 1'b0) begin fails++; $display("FAIL midreset_no_pulse cyc %0d got %b exp 0", n, ov0); end
      end
      start(0, 16'h0003, 16'h0005, 1'b0, 1'b1);
      wait_out(0, lat);
      checks++; if (acc0 !== 24'h00000F) begin fails++; $display("FAIL midreset_next_acc got %h exp 00000f", acc0); end
      checks++; if (p0 !== 16'h000F) begin fails++; $display("FAIL midreset_next_prod got %h exp 000f", p0); end
      pop(0);
   endtask

   task automatic test_wide();
      int lat;
      start(2, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      wait_out(2, lat);
      checks++; if (lat !== 17) begin fails++; $display("FAIL latency16 got %0d exp 17", lat); end
      checks++; if (p2 !== 32'hFFFE0001) begin fails++; $display("FAIL wide_prod got %h exp fffe0001", p2); end
      checks++; if (acc2 !== 32'hFFFE0001) begin fails++; $display("FAIL wide_acc got %h exp fffe0001", acc2); end
      pop(2);
      start(2, 16'h8000, 16'h0002, 1'b1, 1'b0);
      wait_out(2, lat);
      checks++; if (p2 !== 32'hFFFF0000) begin fails++; $display("FAIL wide_signed_prod got %h exp ffff0000", p2); end
      checks++; if (acc2 !== 32'hFFFF0000) begin fails++; $display("FAIL wide_signed_acc got %h exp ffff0000", acc2); end
      pop(2);
   endtask

   initial begin
      test_reset();
      test_unsigned_max();
      test_back_to_back_signed();
      test_acc16_overflow();
      test_backpressure();
      test_reset_mid();
      test_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
